// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between byte-stream clients.
// A grant is held for a whole message, bytes are paced against tx_busy, and a stalled owner is timed out.
module uart_tx_arbiter #(
  parameter int NUM_CLIENTS    = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [8*NUM_CLIENTS-1:0] cli_data,
  input  logic [NUM_CLIENTS-1:0]   cli_valid,
  input  logic [NUM_CLIENTS-1:0]   cli_last,
  output logic [NUM_CLIENTS-1:0]   cli_ready,
  output logic [NUM_CLIENTS-1:0]   grant,
  output logic [7:0]               tx_data,
  output logic                     tx_wr,
  input  logic                     tx_busy,
  output logic                     timeout
);

  localparam int IW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_FIRE = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [IW-1:0] LAST_RST = IW'(NUM_CLIENTS - 1);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    STROBE,
    GUARD
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_CLIENTS-1:0] grant_q, grant_d;
  logic [IW-1:0]          owner_q, owner_d;
  logic [IW-1:0]          last_grant_q, last_grant_d;
  logic [7:0]             tx_data_q, tx_data_d;
  logic                   last_flag_q, last_flag_d;
  logic                   tx_wr_q, tx_wr_d;
  logic                   timeout_q, timeout_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  logic [IW-1:0]          pick_idx;
  logic                   pick_found;
  logic                   owner_valid;
  logic                   owner_last;
  logic [7:0]             owner_data;
  logic                   accept;

  // Search upward from the client after the last owner, wrapping modulo NUM_CLIENTS.
  always_comb begin
    int            cand;
    logic [IW-1:0] cand_idx;
    pick_idx   = '0;
    pick_found = 1'b0;
    cand       = 0;
    cand_idx   = '0;
    for (int k = 1; k <= NUM_CLIENTS; k++) begin
      cand = int'(last_grant_q) + k;
      if (cand >= NUM_CLIENTS) begin
        cand = cand - NUM_CLIENTS;
      end
      cand_idx = IW'(cand);
      if (!pick_found && cli_valid[cand_idx]) begin
        pick_idx   = cand_idx;
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    owner_valid = cli_valid[owner_q];
    owner_last  = cli_last[owner_q];
    owner_data  = cli_data[{owner_q, 3'b000} +: 8];
    accept      = (state_q == XFER) && owner_valid && !tx_busy;
  end

  always_comb begin
    cli_ready = '0;
    if ((state_q == XFER) && !tx_busy) begin
      cli_ready = grant_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    tx_data_d    = tx_data_q;
    last_flag_d  = last_flag_q;
    cnt_d        = cnt_q;
    tx_wr_d      = 1'b0;
    timeout_d    = 1'b0;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (pick_found) begin
          grant_d[pick_idx] = 1'b1;
          owner_d           = pick_idx;
          cnt_d             = '0;
          state_d           = XFER;
        end
      end
      XFER: begin
        if (accept) begin
          tx_data_d   = owner_data;
          last_flag_d = owner_last;
          cnt_d       = '0;
          tx_wr_d     = 1'b1;
          state_d     = STROBE;
        end else if (!owner_valid) begin
          // This idle cycle is the TIMEOUT_CYCLES-th one: release the owner now.
          if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_FIRE)) begin
            timeout_d    = 1'b1;
            last_grant_d = owner_q;
            grant_d      = '0;
            cnt_d        = '0;
            state_d      = IDLE;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      STROBE: begin
        state_d = GUARD;
      end
      GUARD: begin
        if (last_flag_q) begin
          last_grant_d = owner_q;
          grant_d      = '0;
          state_d      = IDLE;
        end else begin
          cnt_d   = '0;
          state_d = XFER;
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      last_grant_q <= LAST_RST;
      tx_data_q    <= 8'h00;
      last_flag_q  <= 1'b0;
      tx_wr_q      <= 1'b0;
      timeout_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      tx_data_q    <= tx_data_d;
      last_flag_q  <= last_flag_d;
      tx_wr_q      <= tx_wr_d;
      timeout_q    <= timeout_d;
      cnt_q        <= cnt_d;
    end
  end

  assign grant   = grant_q;
  assign tx_data = tx_data_q;
  assign tx_wr   = tx_wr_q;
  assign timeout = timeout_q;

endmodule
